parity_frame_tx: RTL and testbench



---
 rtl/parity_frame_tx_pkg.sv | 17 +
 rtl/parity_frame_tx.sv | 101 ++++++++++
 tb/tb_parity_frame_tx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_tx_pkg.sv
// Shared types and sizing helpers for the parity-framed serial transmitter.
package parity_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 8;

  // A one-bit payload still needs a one-bit counter.
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/parity_frame_tx.sv
// Serializes handshaked words MSB first plus a trailing parity bit; all outputs registered.
// Build option PARITY_FRAME_TX_ODD_EN selects odd parity instead of even.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              dataValid,
  output logic              dataReady,
  output logic              seqOut,
  output logic              seqValid,
  output logic              lastBit
);

  localparam int CNT_W = cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef PARITY_FRAME_TX_ODD_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              ready_q, ready_d;
  logic              sout_q, sout_d;
  logic              svld_q, svld_d;
  logic              last_q, last_d;
  logic              accept;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    accept  = dataValid && ready_q;

    case (state_q)
      IDLE, PAR: begin
        if (accept) begin
          shreg_d = dataIn;
          par_d   = (^dataIn) ^ PAR_INV;
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = PAR;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next state so they land in registers one edge early.
    ready_d = (state_d != DATA);
    svld_d  = (state_d != IDLE);
    last_d  = (state_d == PAR);
    case (state_d)
      DATA:    sout_d = shreg_d[DATA_W-1];
      PAR:     sout_d = par_d;
      default: sout_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      sout_q  <= 1'b0;
      svld_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      sout_q  <= sout_d;
      svld_q  <= svld_d;
      last_q  <= last_d;
    end
  end

  assign dataReady = ready_q;
  assign seqOut    = sout_q;
  assign seqValid  = svld_q;
  assign lastBit   = last_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Randomized and directed bench for parity_frame_tx against a frame-level bit queue model.
module tb_parity_frame_tx;

  localparam int W = 8;
`ifdef PARITY_FRAME_TX_ODD_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic         dataValid = 1'b0;
  logic         dataReady, seqOut, seqValid, lastBit;

  parity_frame_tx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(dataReady), .seqOut(seqOut), .seqValid(seqValid), .lastBit(lastBit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit exp_bit[$];
  bit exp_last[$];
  bit rst_edge = 1'b0;
  bit acc = 1'b0;
  int run = 0;
  int last_run = 0;
  int accepted = 0;
  bit hs;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame: payload MSB first, then a bit making the ones-count even (or odd).
  task automatic push_frame(input logic [W-1:0] w);
    int ones = 0;
    for (int i = W - 1; i >= 0; i--) begin
      exp_bit.push_back(w[i]);
      exp_last.push_back(1'b0);
      ones += int'(w[i]);
    end
    exp_bit.push_back(bit'(ones % 2) ^ ODD);
    exp_last.push_back(1'b1);
  endtask

  task automatic monitor();
    bit b, l;
    if (exp_bit.size() > 0) begin
      b = exp_bit.pop_front();
      l = exp_last.pop_front();
      chk("seqValid", seqValid, 1);
      chk("seqOut", seqOut, b);
      chk("lastBit", lastBit, l);
    end else begin
      chk("idle_seqValid", seqValid, 0);
      chk("idle_seqOut", seqOut, 0);
      chk("idle_lastBit", lastBit, 0);
    end
    chk("dataReady", dataReady, rst_edge && (exp_bit.size() == 0));
    if (seqValid === 1'b1) begin
      acc ^= seqOut;
      run++;
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (lastBit === 1'b1) begin
      chk("loop_even", (acc == 1'b0), !ODD);
      acc = 1'b0;
    end
  endtask

  // Applies inputs for the coming rising edge, then checks outputs on the falling edge.
  task automatic drive(input logic v, input logic [W-1:0] d, output bit took);
    dataValid = v;
    dataIn    = d;
    rst_edge  = rst;
    took      = v && (dataReady === 1'b1) && rst;
    if (!rst) begin
      exp_bit.delete();
      exp_last.delete();
      acc = 1'b0;
    end
    if (took) begin
      push_frame(d);
      accepted++;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic send(input logic [W-1:0] w, output int n);
    bit t;
    n = 0;
    do begin
      drive(1'b1, w, t);
      n++;
    end while (!t && n < 40);
    chk("accept_timeout", t, 1);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) drive(1'b0, '0, t);
  endtask

  initial begin
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // Single frames, including an odd-weight payload.
    send(8'hA5, cyc);
    idle(12);
    chk("single_run", last_run, W + 1);
    send(8'h07, cyc);
    idle(12);

    // Back-to-back with valid held: second accept lands on the parity cycle.
    send(8'hFF, cyc);
    send(8'h01, cyc);
    chk("b2b_gap", cyc, W + 1);
    idle(12);
    chk("b2b_run", last_run, 2 * (W + 1));
    send(8'hC3, cyc);
    send(8'h5A, cyc);
    chk("stall_gap", cyc, W + 1);
    idle(12);

    // Reset mid-frame truncates without a parity bit.
    send(8'h3C, cyc);
    idle(4);
    rst = 1'b0;
    idle(1);
    chk("rst_mid_seqValid", seqValid, 0);
    chk("rst_mid_ready", dataReady, 0);
    rst = 1'b1;
    run = 0;
    idle(1);
    send(8'h81, cyc);
    idle(12);
    chk("post_rst_run", last_run, W + 1);

    // Randomized loopback with a hesitant producer that holds each word until taken.
    accepted = 0;
    for (int k = 0; k < 100; k++) begin
      logic [W-1:0] w;
      bit t;
      int guard;
      w = W'($urandom);
      t = 1'b0;
      guard = 0;
      while (!t && guard < 60) begin
        if ($urandom_range(3, 0) != 0) drive(1'b1, w, t);
        else drive(1'b0, W'($urandom), t);
        guard++;
      end
      chk("rand_accept_timeout", t, 1);
      if ($urandom_range(4, 0) == 0) idle($urandom_range(3, 1));
    end
    idle(12);
    chk("rand_accepted", accepted, 100);
    chk("rand_drained", exp_bit.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
